// File: rtl/adc_event_packer_pkg.sv
// adc_event_packer_pkg
//   Shared definitions for the ADC event packer: FIFO word tags, packer
//   state encoding and per-event overhead for both build variants.
//   Build option: `ADC_EVENT_PACKER_TIMESTAMP_EN selects OH_TS over OH_BASE.
package adc_event_packer_pkg;

  localparam logic [1:0] TAG_SAMP = 2'b00;
  localparam logic [1:0] TAG_HDR  = 2'b01;
  localparam logic [1:0] TAG_TS   = 2'b10;
  localparam logic [1:0] TAG_TRL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_TS_HI,
    ST_TS_LO,
    ST_SAMP,
    ST_TRL
  } state_e;

  // Non-sample words per event: header + trailer (+ two timestamp halves).
  localparam int unsigned OH_BASE = 2;
  localparam int unsigned OH_TS   = 4;

endpackage

// File: rtl/adc_event_packer_satcnt.sv
// adc_event_packer_satcnt
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk_i  - clock
//     rst_ni - async active-low reset (counter -> 0)
//     inc_i  - increment request
//     cnt_o  - registered count
module adc_event_packer_satcnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/adc_event_packer.sv
// adc_event_packer
//   Frames a triggered burst of ADC samples as header / [timestamp] /
//   samples / trailer tagged 18-bit words and writes them into the
//   downstream sample FIFO. A trigger is only accepted when the FIFO has
//   room for the whole event, so only complete events are stored.
//   Build option: `ADC_EVENT_PACKER_TIMESTAMP_EN adds a free-running 32-bit
//   cycle counter captured on accept and two timestamp words after the header.
//   Ports:
//     CLK, RESET_N      clock, async active-low reset
//     ENABLE            accept triggers when high
//     EVT_LEN           samples per event, latched on accept (0 allowed)
//     ADC_DATA/VALID    sample stream
//     TRIG              trigger level, sampled every cycle
//     FIFO_WRCNT/FULL   FIFO occupancy and full flag
//     FIFO_DATA/WE      FIFO write port ([17:16] tag, [15:0] payload)
//     BUSY              event in progress
//     EVT_CNT           accepted events (wraps)
//     DROP_CNT          rejected triggers (saturates)
//     OVF_ERR/OVF_CLR   sticky suppressed-write flag and its clear
module adc_event_packer
  import adc_event_packer_pkg::*;
#(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned FIFO_DEPTH   = 16384,
  parameter int unsigned CNT_W        = 15,
  parameter int unsigned LEN_W        = 14,
  parameter int unsigned SPACE_MARGIN = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              ENABLE,
  input  logic [LEN_W-1:0]  EVT_LEN,
  input  logic [DATA_W-1:0] ADC_DATA,
  input  logic              ADC_VALID,
  input  logic              TRIG,
  input  logic [CNT_W-1:0]  FIFO_WRCNT,
  input  logic              FIFO_FULL,
  output logic [DATA_W+1:0] FIFO_DATA,
  output logic              FIFO_WE,
  output logic              BUSY,
  output logic [15:0]       EVT_CNT,
  output logic [15:0]       DROP_CNT,
  output logic              OVF_ERR,
  input  logic              OVF_CLR
);

`ifdef ADC_EVENT_PACKER_TIMESTAMP_EN
  localparam int unsigned OH = OH_TS;
`else
  localparam int unsigned OH = OH_BASE;
`endif

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  samp_cnt_q, samp_cnt_d;
  logic [15:0]       evt_cnt_q;
  logic              ovf_in_evt_q, ovf_err_q, busy_q, we_q;
  logic [DATA_W+1:0] data_q;

  logic              accept, reject, wr_req, wr_ovf;
  logic [DATA_W+1:0] wr_word;
  logic [CNT_W:0]    free_w, need_w;
  logic              space_ok;

`ifdef ADC_EVENT_PACKER_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, ts_cap_q;
`endif

  // Unsigned compare one bit wider than WRCNT so a full FIFO (WRCNT = DEPTH) is exact.
  assign free_w   = (CNT_W+1)'(FIFO_DEPTH) - {1'b0, FIFO_WRCNT};
  assign need_w   = (CNT_W+1)'(EVT_LEN) + (CNT_W+1)'(OH + SPACE_MARGIN);
  assign space_ok = (free_w >= need_w);

  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    accept     = 1'b0;
    reject     = 1'b0;
    wr_req     = 1'b0;
    wr_word    = '0;
    case (state_q)
      ST_IDLE: begin
        if (ENABLE && TRIG) begin
          if (space_ok) begin
            accept     = 1'b1;
            state_d    = ST_HDR;
            samp_cnt_d = '0;
            wr_req     = 1'b1;
            wr_word    = {TAG_HDR, evt_cnt_q + 16'd1};
          end else begin
            reject = 1'b1;
          end
        end
      end
`ifdef ADC_EVENT_PACKER_TIMESTAMP_EN
      ST_HDR: begin
        state_d = ST_TS_HI;
        wr_req  = 1'b1;
        wr_word = {TAG_TS, ts_cap_q[31:16]};
      end
      ST_TS_HI: begin
        state_d = ST_TS_LO;
        wr_req  = 1'b1;
        wr_word = {TAG_TS, ts_cap_q[15:0]};
      end
      ST_TS_LO,
`else
      ST_HDR,
`endif
      // Leaving the last framing word: the sample taken on this edge is the
      // first sample write, keeping header and samples back-to-back.
      ST_SAMP: begin
        if (samp_cnt_q == len_q) begin
          state_d = ST_TRL;
          wr_req  = 1'b1;
          wr_word = {TAG_TRL, 1'b0, ovf_in_evt_q, len_q};
        end else begin
          state_d = ST_SAMP;
          if (ADC_VALID) begin
            samp_cnt_d = samp_cnt_q + LEN_W'(1);
            wr_req     = 1'b1;
            wr_word    = {TAG_SAMP, ADC_DATA};
          end
        end
      end
      ST_TRL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if ((state_q != ST_IDLE) && ENABLE && TRIG) begin
      reject = 1'b1;
    end
  end

  assign wr_ovf = wr_req && FIFO_FULL;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      samp_cnt_q   <= '0;
      evt_cnt_q    <= '0;
      ovf_in_evt_q <= 1'b0;
      ovf_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      we_q         <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      busy_q     <= (state_d != ST_IDLE);
      we_q       <= wr_req && !FIFO_FULL;
      data_q     <= wr_word;
      if (accept) begin
        len_q     <= EVT_LEN;
        evt_cnt_q <= evt_cnt_q + 16'd1;
      end
      // A suppressed header must still be reported by that event's trailer.
      if (accept) begin
        ovf_in_evt_q <= wr_ovf;
      end else if (wr_ovf) begin
        ovf_in_evt_q <= 1'b1;
      end
      if (wr_ovf) begin
        ovf_err_q <= 1'b1;
      end else if (OVF_CLR) begin
        ovf_err_q <= 1'b0;
      end
    end
  end

`ifdef ADC_EVENT_PACKER_TIMESTAMP_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ts_cnt_q <= '0;
      ts_cap_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (accept) begin
        ts_cap_q <= ts_cnt_q;
      end
    end
  end
`endif

  adc_event_packer_satcnt #(
    .W (16)
  ) u_drop_cnt (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .inc_i  (reject),
    .cnt_o  (DROP_CNT)
  );

  assign FIFO_DATA = data_q;
  assign FIFO_WE   = we_q;
  assign BUSY      = busy_q;
  assign EVT_CNT   = evt_cnt_q;
  assign OVF_ERR   = ovf_err_q;

endmodule

// File: tb/tb_adc_event_packer.sv
// tb_adc_event_packer
//   Directed bench for adc_event_packer. A negedge monitor records every
//   FIFO write with its cycle number; each step then checks the recorded
//   words, their spacing and the status outputs against hand-computed values.
//   Build option: `ADC_EVENT_PACKER_TIMESTAMP_EN runs the timestamp scenario.
module tb_adc_event_packer;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        ENABLE = 1'b0;
  logic [13:0] EVT_LEN = '0;
  logic [15:0] ADC_DATA = '0;
  logic        ADC_VALID = 1'b0;
  logic        TRIG = 1'b0;
  logic [14:0] FIFO_WRCNT = '0;
  logic        FIFO_FULL = 1'b0;
  logic        OVF_CLR = 1'b0;
  logic [17:0] FIFO_DATA;
  logic        FIFO_WE;
  logic        BUSY;
  logic [15:0] EVT_CNT;
  logic [15:0] DROP_CNT;
  logic        OVF_ERR;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          busy_n = 0;
  logic [31:0] tb_ts = '0;
  logic [17:0] wq[$];
  int          wc[$];
  int          base;
  int          b0;

  adc_event_packer #(
    .DATA_W       (16),
    .FIFO_DEPTH   (16384),
    .CNT_W        (15),
    .LEN_W        (14),
    .SPACE_MARGIN (4)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .ENABLE     (ENABLE),
    .EVT_LEN    (EVT_LEN),
    .ADC_DATA   (ADC_DATA),
    .ADC_VALID  (ADC_VALID),
    .TRIG       (TRIG),
    .FIFO_WRCNT (FIFO_WRCNT),
    .FIFO_FULL  (FIFO_FULL),
    .FIFO_DATA  (FIFO_DATA),
    .FIFO_WE    (FIFO_WE),
    .BUSY       (BUSY),
    .EVT_CNT    (EVT_CNT),
    .DROP_CNT   (DROP_CNT),
    .OVF_ERR    (OVF_ERR),
    .OVF_CLR    (OVF_CLR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RESET_N) tb_ts <= tb_ts + 32'd1;
  end

  always @(negedge CLK) begin
    if (FIFO_WE === 1'b1) begin
      wq.push_back(FIFO_DATA);
      wc.push_back(cyc);
    end
    if (BUSY === 1'b1) busy_n = busy_n + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int idx);
    if (idx < wq.size()) return 32'(wq[idx]);
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] gap(input int a, input int b);
    if ((a < wc.size()) && (b < wc.size())) return 32'(wc[b] - wc[a]);
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    step(3);
    chk("rst_we",   32'(FIFO_WE),   32'h0);
    chk("rst_data", 32'(FIFO_DATA), 32'h0);
    chk("rst_busy", 32'(BUSY),      32'h0);
    chk("rst_evt",  32'(EVT_CNT),   32'h0);
    chk("rst_drop", 32'(DROP_CNT),  32'h0);
    chk("rst_ovf",  32'(OVF_ERR),   32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    step(2);

`ifdef ADC_EVENT_PACKER_TIMESTAMP_EN
    // Timestamp build: accept exactly when the cycle counter reads 0x0001_2345.
    ENABLE = 1'b1; EVT_LEN = 14'd2; ADC_VALID = 1'b1; ADC_DATA = 16'h6666;
    for (int g = 0; (g < 80000) && (tb_ts < 32'h0001_2345); g++) step(1);
    chk("ts_reach", tb_ts, 32'h0001_2345);
    base = wq.size();
    TRIG = 1'b1; step(1); TRIG = 1'b0;
    step(8);
    ADC_VALID = 1'b0;
    chk("t6_n",    32'(wq.size() - base), 32'd6);
    chk("t6_hdr",  word_at(base),     32'h1_0001);
    chk("t6_tshi", word_at(base + 1), 32'h2_0001);
    chk("t6_tslo", word_at(base + 2), 32'h2_2345);
    chk("t6_s0",   word_at(base + 3), 32'h0_6666);
    chk("t6_s1",   word_at(base + 4), 32'h0_6666);
    chk("t6_trl",  word_at(base + 5), 32'h3_0002);
    chk("t6_gap",  gap(base, base + 5), 32'd5);
`else
    // 1: three samples with continuous valid, five back-to-back words.
    base = wq.size(); b0 = busy_n;
    ENABLE = 1'b1; EVT_LEN = 14'd3; FIFO_WRCNT = '0;
    ADC_VALID = 1'b1; ADC_DATA = 16'hA0A0; TRIG = 1'b1;
    step(1);
    TRIG = 1'b0; step(1);
    ADC_DATA = 16'hB1B1; step(1);
    ADC_DATA = 16'hC2C2; step(1);
    ADC_DATA = 16'hD3D3; step(4);
    ADC_VALID = 1'b0;
    chk("t1_n",    32'(wq.size() - base), 32'd5);
    chk("t1_hdr",  word_at(base),     32'h1_0001);
    chk("t1_s0",   word_at(base + 1), 32'h0_A0A0);
    chk("t1_s1",   word_at(base + 2), 32'h0_B1B1);
    chk("t1_s2",   word_at(base + 3), 32'h0_C2C2);
    chk("t1_trl",  word_at(base + 4), 32'h3_0003);
    chk("t1_gap",  gap(base, base + 4), 32'd4);
    chk("t1_busy", 32'(busy_n - b0), 32'd5);
    chk("t1_evt",  32'(EVT_CNT), 32'd1);

    // 2: four samples with valid toggling; writes only after valid cycles.
    base = wq.size();
    EVT_LEN = 14'd4; TRIG = 1'b1; step(1); TRIG = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ADC_VALID = ((i % 2) == 0);
      ADC_DATA  = 16'(16'h1111 * (i / 2 + 1));
      step(1);
    end
    ADC_VALID = 1'b0;
    chk("t2_n",    32'(wq.size() - base), 32'd6);
    chk("t2_hdr",  word_at(base),     32'h1_0002);
    chk("t2_s0",   word_at(base + 1), 32'h0_1111);
    chk("t2_s3",   word_at(base + 4), 32'h0_4444);
    chk("t2_trl",  word_at(base + 5), 32'h3_0004);
    chk("t2_sgap", gap(base + 1, base + 2), 32'd2);
    chk("t2_tgap", gap(base + 4, base + 5), 32'd1);

    // 3: space check boundary, free 104 < 106 rejected, free 106 accepted.
    base = wq.size();
    EVT_LEN = 14'd100; FIFO_WRCNT = 15'd16280;
    TRIG = 1'b1; step(1); TRIG = 1'b0; step(3);
    chk("t3_rej_n",    32'(wq.size() - base), 32'd0);
    chk("t3_rej_drop", 32'(DROP_CNT), 32'd1);
    chk("t3_rej_evt",  32'(EVT_CNT),  32'd2);
    chk("t3_rej_busy", 32'(BUSY),     32'd0);
    FIFO_WRCNT = 15'd16278;
    TRIG = 1'b1; step(1); TRIG = 1'b0;
    chk("t3_acc_busy", 32'(BUSY),    32'd1);
    chk("t3_acc_evt",  32'(EVT_CNT), 32'd3);
    ADC_VALID = 1'b1; ADC_DATA = 16'h0055;
    step(105);
    ADC_VALID = 1'b0; FIFO_WRCNT = '0;
    step(2);
    chk("t3_n",   32'(wq.size() - base), 32'd102);
    chk("t3_hdr", word_at(base),       32'h1_0003);
    chk("t3_trl", word_at(base + 101), 32'h3_0064);

    // 4: trigger during SAMP counts a drop only with ENABLE high; no abort.
    base = wq.size();
    EVT_LEN = 14'd5; ADC_VALID = 1'b1; ADC_DATA = 16'h0077;
    TRIG = 1'b1; step(1); TRIG = 1'b0; step(2);
    TRIG = 1'b1; step(1); TRIG = 1'b0;
    chk("t4_drop_en", 32'(DROP_CNT), 32'd2);
    ENABLE = 1'b0; TRIG = 1'b1; step(1); TRIG = 1'b0;
    chk("t4_drop_dis", 32'(DROP_CNT), 32'd2);
    ENABLE = 1'b1; step(6);
    ADC_VALID = 1'b0; step(2);
    chk("t4_n",   32'(wq.size() - base), 32'd7);
    chk("t4_hdr", word_at(base),     32'h1_0004);
    chk("t4_trl", word_at(base + 6), 32'h3_0005);
    chk("t4_evt", 32'(EVT_CNT), 32'd4);

    // 5: FIFO_FULL on the second sample write; trailer flags the loss.
    base = wq.size();
    EVT_LEN = 14'd3; ADC_VALID = 1'b1; ADC_DATA = 16'hAAAA;
    TRIG = 1'b1; step(1); TRIG = 1'b0; step(1);
    ADC_DATA = 16'hBBBB; FIFO_FULL = 1'b1; step(1);
    chk("t5_we_sup", 32'(FIFO_WE), 32'd0);
    chk("t5_ovf",    32'(OVF_ERR), 32'd1);
    FIFO_FULL = 1'b0; ADC_DATA = 16'hCCCC; step(2);
    ADC_VALID = 1'b0; step(2);
    chk("t5_n",   32'(wq.size() - base), 32'd4);
    chk("t5_s0",  word_at(base + 1), 32'h0_AAAA);
    chk("t5_s2",  word_at(base + 2), 32'h0_CCCC);
    chk("t5_trl", word_at(base + 3), 32'h3_4003);
    chk("t5_ovf_hold", 32'(OVF_ERR), 32'd1);
    OVF_CLR = 1'b1; step(1); OVF_CLR = 1'b0;
    chk("t5_ovf_clr", 32'(OVF_ERR), 32'd0);

    // 6: zero-length events with TRIG held high; re-accept right after TRL.
    base = wq.size();
    EVT_LEN = 14'd0; TRIG = 1'b1; step(4); TRIG = 1'b0; step(3);
    chk("t7_n",    32'(wq.size() - base), 32'd4);
    chk("t7_hdr0", word_at(base),     32'h1_0006);
    chk("t7_trl0", word_at(base + 1), 32'h3_0000);
    chk("t7_hdr1", word_at(base + 2), 32'h1_0007);
    chk("t7_trl1", word_at(base + 3), 32'h3_0000);
    chk("t7_gap",  gap(base + 1, base + 2), 32'd2);
    chk("t7_drop", 32'(DROP_CNT), 32'd4);
    chk("t7_evt",  32'(EVT_CNT),  32'd7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
